key_bounce_gen: RTL and testbench

//  Synthesizable mechanical-key emulator: the drive side of the key debounce path.
//  On a handshaked press request, drives an active-low key line through three phases:

---
 rtl/key_pkg.sv | 22 ++
 rtl/lfsr16.sv | 21 ++
 rtl/key_bounce_gen.sv | 122 ++++++++++++
 tb/tb_key_bounce_gen.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared encodings for the key bounce emulator: FSM states, LFSR taps, key line polarity.
// Pure definitions; no logic, no latency, no flow control.
package key_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_B_PRESS = 2'd1;
  localparam state_t ST_HOLD    = 2'd2;
  localparam state_t ST_B_REL   = 2'd3;

  // Galois mask for x^16 + x^14 + x^13 + x^11 (right-shifting form)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam logic KEY_RELEASED = 1'b1;

  // An all-zero seed would lock the LFSR, so it is mapped to 1.
  function automatic logic [15:0] fix_seed(input logic [15:0] seed);
    return (seed == 16'h0000) ? 16'h0001 : seed;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR, one step per enabled cycle; q is the registered state.
// No backpressure: en simply freezes the register.
module lfsr16
  import key_pkg::*;
(
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [15:0] seed,
  input  logic        en,
  output logic [15:0] q
);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      q <= fix_seed(seed);
    end else if (en) begin
      q <= {1'b0, q[15:1]} ^ (q[0] ? LFSR_TAPS : 16'h0000);
    end
  end

endmodule

// File: rtl/key_bounce_gen.sv
// Mechanical key emulator: press bounce, stable low hold, release bounce; outputs registered, key_out follows accept edge.
// Request accepted only when idle; req_valid while busy is ignored until the sequence completes.
module key_bounce_gen
  import key_pkg::*;
#(
  parameter int              CNT_W      = 21,
  parameter logic [CNT_W-1:0] BOUNCE_CNT = CNT_W'(99_999),
  parameter logic [15:0]      LFSR_SEED  = 16'hACE1
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             req_valid,
  input  logic [CNT_W-1:0] req_hold,
  output logic             req_ready,
  output logic             key_out,
  output logic             busy,
  output logic             done
);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] hold_r;
  logic [15:0]      lfsr_q;
  logic             accept;
  logic             key_nxt;
  logic             busy_nxt;
  logic             done_nxt;

  assign req_ready = (state == ST_IDLE);
  assign accept    = req_valid & req_ready;

  // Free-running: stepping in IDLE too keeps the trace a pure function of request timing.
  lfsr16 u_lfsr (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .seed    (LFSR_SEED),
    .en      (1'b1),
    .q       (lfsr_q)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      hold_r <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        hold_r <= req_hold;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = ST_B_PRESS;
          cnt_nxt   = '0;
        end
      end
      ST_B_PRESS: begin
        if (cnt == BOUNCE_CNT) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (cnt == hold_r) begin
          state_nxt = ST_B_REL;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_B_REL: begin
        if (cnt == BOUNCE_CNT) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Output values are decoded from the state being entered, then registered.
  always_comb begin
    key_nxt  = KEY_RELEASED;
    busy_nxt = (state_nxt != ST_IDLE);
    done_nxt = (state == ST_B_REL) && (state_nxt == ST_IDLE);
    case (state_nxt)
      ST_B_PRESS, ST_B_REL: key_nxt = lfsr_q[0];
      ST_HOLD:              key_nxt = 1'b0;
      default:              key_nxt = KEY_RELEASED;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      key_out <= KEY_RELEASED;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      key_out <= key_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
    end
  end

endmodule

// File: tb/tb_key_bounce_gen.sv
// Bench for key_bounce_gen with short bounce phases: reference model predicts traces, monitor checks.
module tb_key_bounce_gen;

  localparam int          CNT_W = 21;
  localparam int          NB    = 10;
  localparam logic [15:0] SEED  = 16'hACE1;

  logic             sys_clk;
  logic             sys_rst;
  logic             req_valid;
  logic [CNT_W-1:0] req_hold;
  logic             req_ready;
  logic             key_out;
  logic             busy;
  logic             done;

  int tests  = 0;
  int failed = 0;

  logic [15:0] m_lfsr;
  int          m_rem   = 0;
  logic        m_done  = 1'b0;
  logic        armed   = 1'b0;
  int          cap_sel = 0;
  bit          exp_key[$];
  bit          cap_a[$];
  bit          cap_b[$];

  key_bounce_gen #(
    .CNT_W      (CNT_W),
    .BOUNCE_CNT (21'd9),
    .LFSR_SEED  (SEED)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .req_valid (req_valid),
    .req_hold  (req_hold),
    .req_ready (req_ready),
    .key_out   (key_out),
    .busy      (busy),
    .done      (done)
  );

  initial sys_clk = 1'b0;
  always #10 sys_clk = ~sys_clk;

  // Galois step written out tap by tap: bits 15,13,12,10 receive the output bit.
  function automatic logic [15:0] m_step(input logic [15:0] x);
    logic [15:0] n;
    n[15]  = x[0];
    n[14]  = x[15];
    n[13]  = x[14] ^ x[0];
    n[12]  = x[13] ^ x[0];
    n[11]  = x[12];
    n[10]  = x[11] ^ x[0];
    n[9:0] = x[10:1];
    return n;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: advances on each rising edge, pushes the full expected key trace on accept.
  always @(posedge sys_clk) begin
    logic        acc;
    logic [15:0] t;
    int          total;
    int          h;
    if (sys_rst) begin
      m_lfsr = SEED;
      m_rem  = 0;
      m_done = 1'b0;
      exp_key.delete();
      armed  = 1'b1;
    end else begin
      acc    = req_valid && (m_rem == 0);
      m_done = (m_rem == 1);
      if (acc) begin
        h     = int'(req_hold);
        total = 2 * NB + h + 1;
        t     = m_lfsr;
        for (int k = 0; k < total; k++) begin
          if (k < NB || k >= NB + h + 1) exp_key.push_back(t[0]);
          else                           exp_key.push_back(1'b0);
          t = m_step(t);
        end
        m_rem = total;
      end else if (m_rem > 0) begin
        m_rem = m_rem - 1;
      end
      m_lfsr = m_step(m_lfsr);
    end
  end

  // Monitor: samples on the falling edge; pops an expected key bit whenever the DUT drives the line.
  always @(negedge sys_clk) begin
    bit e;
    if (armed) begin
      chk("req_ready", req_ready, m_rem == 0);
      chk("busy", busy, m_rem != 0);
      chk("done", done, m_done);
      if (busy) begin
        chk("key_queue_nonempty", exp_key.size() != 0, 1);
        if (exp_key.size() != 0) begin
          e = exp_key.pop_front();
          chk("key_out_driven", key_out, e);
        end
        if (cap_sel == 1) cap_a.push_back(key_out);
        if (cap_sel == 2) cap_b.push_back(key_out);
      end else begin
        chk("key_out_idle", key_out, 1'b1);
      end
    end
  end

  task automatic pulse_req(input int h);
    @(posedge sys_clk); #1;
    req_hold  = CNT_W'(h);
    req_valid = 1'b1;
    @(posedge sys_clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (m_rem != 0 && n < 500) begin
      @(posedge sys_clk);
      n++;
    end
    chk("idle_timeout", n < 500, 1);
    repeat (2) @(posedge sys_clk);
    #1;
  endtask

  task automatic reset_and_run(input int sel);
    sys_rst = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    cap_sel = sel;
    repeat (2) @(posedge sys_clk);
    #1;
    pulse_req(19);
    wait_idle();
    cap_sel = 0;
  endtask

  initial begin
    sys_rst   = 1'b1;
    req_valid = 1'b0;
    req_hold  = '0;

    // reset state, then a single 40-cycle sequence with hold 19
    reset_and_run(1);
    chk("trace_len_a", cap_a.size(), 40);

    // req_valid held high: back-to-back sequences, busy requests ignored
    @(posedge sys_clk); #1;
    req_hold  = CNT_W'(3);
    req_valid = 1'b1;
    repeat (60) @(posedge sys_clk);
    #1;
    req_valid = 1'b0;
    wait_idle();

    // minimum hold: one stable low cycle
    pulse_req(0);
    wait_idle();

    // reset in the middle of the hold phase
    pulse_req(19);
    repeat (15) @(posedge sys_clk);
    #1;
    sys_rst = 1'b1;
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("ready_after_midreset", req_ready, 1'b1);

    // same seed and timing must reproduce the first trace bit for bit
    reset_and_run(2);
    chk("trace_len_b", cap_b.size(), 40);
    for (int i = 0; i < 40; i++) begin
      if (i < cap_a.size() && i < cap_b.size()) chk("trace_repeat", cap_b[i], cap_a[i]);
    end
    chk("queue_drained", exp_key.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
